// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: operands and start in,
// status and registered result out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, controlled by an
// IDLE/RUN/DONE FSM with registered busy/done/sum/cout.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;

  // Full-adder slice on the current LSB pair
  always_comb begin
    s_bit    = op_a[0] ^ op_b[0] ^ carry;
    c_next   = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    acc_next = {s_bit, acc[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.a;
            op_b     <= bus.b;
            carry    <= bus.cin;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= acc_next;
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          // The final bit goes straight to the result so sum lands with done
          if (last_bit) begin
            bus.sum  <= acc_next;
            bus.cout <= c_next;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench for serial_adder_fsm at WIDTH=8 and WIDTH=4: stimulus pushes
// a+b+cin with its due cycle; per-instance monitors pop and compare on done.
module tb_serial_adder_fsm;

  typedef struct {
    logic [32:0] res;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst8_n;
  logic rst4_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t        q8[$];
  exp_t        q4[$];
  logic [32:0] last8;
  logic [32:0] last4;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder_fsm #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));
  serial_adder_fsm #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors: result on done must match the oldest expectation and its due cycle;
  // otherwise sum/cout must hold the last completed result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst8_n) last8 = '0;
    check("busy_done_excl8", longint'(bus8.busy & bus8.done), 0);
    if (bus8.done) begin
      if (q8.size() == 0) check("spurious_done8", longint'(bus8.done), 0);
      else begin
        e = q8.pop_front();
        check("result8", longint'({bus8.cout, bus8.sum}), longint'(e.res));
        check("latency8", longint'(cyc), longint'(e.cyc));
        last8 = e.res;
      end
    end else begin
      check("hold8", longint'({bus8.cout, bus8.sum}), longint'(last8));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst4_n) last4 = '0;
    check("busy_done_excl4", longint'(bus4.busy & bus4.done), 0);
    if (bus4.done) begin
      if (q4.size() == 0) check("spurious_done4", longint'(bus4.done), 0);
      else begin
        e = q4.pop_front();
        check("result4", longint'({bus4.cout, bus4.sum}), longint'(e.res));
        check("latency4", longint'(cyc), longint'(e.cyc));
        last4 = e.res;
      end
    end else begin
      check("hold4", longint'({bus4.cout, bus4.sum}), longint'(last4));
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input bit perturb);
    int nb;
    exp_t e;
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.cin   = cv;
    e.res = 33'(av) + 33'(bv) + 33'(cv);
    e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
      end
      if (perturb && i == 2) begin
        bus8.start = 1'b1;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
      end
      if (perturb && i == 3) bus8.start = 1'b0;
      if (bus8.busy) nb++;
    end
    check("busy_len8", longint'(nb), 8);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    int nb;
    exp_t e;
    bus4.start = 1'b1;
    bus4.a     = av;
    bus4.b     = bv;
    bus4.cin   = cv;
    e.res = 33'(av) + 33'(bv) + 33'(cv);
    e.cyc = cyc + 1 + 4;
    q4.push_back(e);
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus4.start = 1'b0;
        bus4.a     = 4'($urandom);
        bus4.b     = 4'($urandom);
        bus4.cin   = 1'($urandom);
      end
      if (bus4.busy) nb++;
    end
    check("busy_len4", longint'(nb), 4);
  endtask

  task automatic held8();
    exp_t e;
    int   c0;
    c0 = cyc;
    bus8.start = 1'b1;
    bus8.a     = 8'hFF;
    bus8.b     = 8'h01;
    bus8.cin   = 1'b0;
    e.res = 33'h100;
    e.cyc = c0 + 1 + 8;
    q8.push_back(e);
    e.res = 33'h080;
    e.cyc = c0 + 1 + 10 + 8;
    q8.push_back(e);
    @(negedge clk);
    bus8.a = 8'h7F;
    bus8.b = 8'h01;
    repeat (9) @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    repeat (9) @(negedge clk);
  endtask

  task automatic reset_mid_run8();
    bus8.start = 1'b1;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1;
    check("abort_busy8", longint'(bus8.busy), 0);
    check("abort_done8", longint'(bus8.done), 0);
    check("abort_sum8",  longint'(bus8.sum), 0);
    check("abort_cout8", longint'(bus8.cout), 0);
    @(negedge clk);
    @(negedge clk);
    rst8_n = 1'b1;
  endtask

  task automatic thread8();
    op8(8'h01, 8'hFF, 1'b0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1, 1'b0);
    op8(8'h3C, 8'h42, 1'b0, 1'b0);
    op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    reset_mid_run8();
    op8(8'h10, 8'h20, 1'b0, 1'b0);
    held8();
    repeat (200) op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic thread4();
    op4(4'hF, 4'h1, 1'b1);
    repeat (1000) op4(4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last8  = '0;
    last4  = '0;
    rst8_n = 1'b0;
    rst4_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    #3;
    check("rst_busy8", longint'(bus8.busy), 0);
    check("rst_done8", longint'(bus8.done), 0);
    check("rst_res8",  longint'({bus8.cout, bus8.sum}), 0);
    check("rst_busy4", longint'(bus4.busy), 0);
    check("rst_res4",  longint'({bus4.cout, bus4.sum}), 0);
    @(negedge clk);
    @(negedge clk);
    rst8_n = 1'b1;
    rst4_n = 1'b1;
    fork
      thread8();
      thread4();
    join
    repeat (3) @(negedge clk);
    check("pending8", longint'(q8.size()), 0);
    check("pending4", longint'(q4.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_fsm.md
SERIAL_ADDER_FSM -- requirements
Module: serial_adder_fsm

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to begin an addition, sampled on rising clk.
REQ-005 SHALL have port: a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress (state RUN).
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result, A+B+cin mod 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL implement a bit-serial adder: one full-adder bit (s = a^b^c, c' = majority(a,b,c)) per clk cycle, LSB first.
REQ-013 SHALL have a 3-state FSM: IDLE, RUN, DONE; reset state IDLE.
REQ-014 In IDLE with start=1 at edge E0: latch a, b into internal shift registers and cin into the carry flop, clear bit counter to 0, go to RUN.
REQ-015 In IDLE with start=0: hold state, and hold sum/cout.
REQ-016 In RUN: each edge SHALL process the current LSB pair, shift the operand registers right by one, shift s into the MSB of an internal accumulator, update the carry flop, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH edges (E1..E_WIDTH); at E_WIDTH the final accumulator and carry SHALL be loaded into sum/cout and the state SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle; done=1 only in DONE; next edge returns to IDLE unconditionally.
REQ-019 Latency: done high during the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after start is accepted.
REQ-020 busy SHALL be 1 exactly in RUN; busy and done SHALL never both be 1.
REQ-021 start SHALL be ignored in RUN and DONE; operands, counter and result SHALL be unaffected by it.
REQ-022 A start held high continuously SHALL be accepted again in the first IDLE cycle after DONE (one new operation every WIDTH+2 cycles).
REQ-023 sum/cout SHALL change only at the RUN->DONE edge and SHALL hold their value through IDLE and the entire next RUN until that operation completes.
REQ-024 Changes on a, b, cin outside the accepting edge SHALL have no effect.
REQ-025 Counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL not wrap within a run.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, sum=0, cout=0, and clear counter, carry, operand and accumulator registers.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and sum/cout SHALL read 0.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=8, a=8'h01, b=8'hFF, cin=0, start pulse -> busy high 8 cycles, done pulse on the 9th edge after start, sum=8'h00, cout=1.
REQ-030 WIDTH=8, a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0.
REQ-031 Start pulsed again during RUN, with a/b changed mid-run -> result unchanged from the operands originally latched; exactly one done pulse.
REQ-032 rst_n pulsed low at cycle 4 of RUN -> busy, done, sum and cout go to 0 immediately; no done; a following start with 8'h10+8'h20 gives 8'h30.
REQ-033 start held high across two operations (8'hFF+8'h01, then 8'h7F+8'h01) -> done pulses 10 edges apart; results 8'h00/cout=1, then 8'h80/cout=0.
REQ-034 WIDTH=4, a=4'hF, b=4'h1, cin=1 -> done on the 5th edge after start, sum=4'h1, cout=1; random self-check of 1000 vectors against a+b+cin.
